// File: rtl/adc_pkg.sv
// adc_pkg: scheduler state encoding, converter-core error codes and status bit positions
package adc_pkg;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_SETTLE = 3'd1;
  localparam logic [2:0] ST_START = 3'd2;
  localparam logic [2:0] ST_WAIT = 3'd3;
  localparam logic [2:0] ST_CAPTURE = 3'd4;
  typedef enum logic [2:0] {
    S_IDLE = ST_IDLE,
    S_SETTLE = ST_SETTLE,
    S_START = ST_START,
    S_WAIT = ST_WAIT,
    S_CAPTURE = ST_CAPTURE
  } sched_state_t;
  localparam logic [2:0] ERR_NONE = 3'd0;
  localparam logic [2:0] ERR_OVR_POS = 3'd1;
  localparam logic [2:0] ERR_OVR_NEG = 3'd2;
  localparam logic [2:0] ERR_RUNDOWN = 3'd3;
  localparam logic [2:0] ERR_N0 = 3'd4;
  localparam logic [2:0] ERR_N1 = 3'd5;
  localparam int STAT_BUSY = 0;
  localparam int STAT_CORE_ERR = 1;
  localparam int STAT_TIMEOUT = 2;
  localparam int STAT_OVERFLOW = 3;
endpackage

// File: rtl/adc_result_fifo.sv
// adc_result_fifo: shift-register FIFO whose head entry doubles as the output register
module adc_result_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int CW = $clog2(DEPTH + 1);
  logic [DEPTH*WIDTH-1:0] q, q_d;
  logic [CW-1:0] cnt;
  logic do_pop, do_push;
  assign empty = cnt == '0;
  assign full = cnt == CW'(DEPTH);
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = q[WIDTH-1:0];
  // Pop shifts toward the head first, so a simultaneous push lands behind the survivors
  always_comb begin
    q_d = do_pop ? q >> WIDTH : q;
    if (do_push) q_d[(int'(cnt) - int'(do_pop)) * WIDTH +: WIDTH] = din;
  end
  // Storage and occupancy
  always_ff @(posedge clk)
    if (rst) begin
      q <= '0;
      cnt <= '0;
    end else begin
      q <= q_d;
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
endmodule

// File: rtl/adc_conv_scheduler.sv
// adc_conv_scheduler: runs settle/start/wait/capture conversion cycles and buffers results (ADC_AUTOZERO_EN adds zero/input auto-zero)
module adc_conv_scheduler
  import adc_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int NPLC_W = 10,
  parameter int SETTLE_MS = 2,
  parameter int TIMEOUT_MS = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick_1ms,
  input  logic              enable,
  input  logic [NPLC_W-1:0] nplc,
  output logic              conv_start,
  output logic              sel_zero,
  input  logic              conv_done,
  input  logic [2:0]        conv_err,
  input  logic [CNT_W-1:0]  conv_result,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [CNT_W-1:0]  res_data,
  input  logic              stat_clr,
  output logic [3:0]        stat
);
  localparam int SW = $clog2(SETTLE_MS + 1);
  localparam int TW = $clog2((1 << NPLC_W) + TIMEOUT_MS + 1);
  logic [2:0] state, state_d;
  logic [SW-1:0] scnt;
  logic [TW-1:0] tcnt, lim;
  logic [NPLC_W-1:0] nplc_q;
  logic [CNT_W-1:0] raw_q, push_data;
  logic [2:0] err_q;
  logic ph, settle_hit, to_hit, push, full, empty, ovf, tmo, cerr;
  assign lim = TW'(nplc_q) + TW'(TIMEOUT_MS);
  assign settle_hit = tick_1ms && scnt == SW'(SETTLE_MS - 1);
  assign to_hit = tick_1ms && tcnt + TW'(1) == lim;
  assign push = state == ST_CAPTURE && err_q == ERR_NONE && !ph;
  assign conv_start = state == ST_START;
  assign sel_zero = ph;
  assign res_valid = !empty;
  // Next state: a done pulse in WAIT takes priority over the final timeout tick
  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE: state_d = enable ? ST_SETTLE : ST_IDLE;
      ST_SETTLE: state_d = settle_hit ? ST_START : ST_SETTLE;
      ST_START: state_d = ST_WAIT;
      ST_WAIT: state_d = conv_done ? ST_CAPTURE : to_hit ? ST_IDLE : ST_WAIT;
      ST_CAPTURE: state_d = enable ? ST_SETTLE : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end
  // Sequencer state, tick counters and the latched core outputs used during CAPTURE
  always_ff @(posedge clk)
    if (rst) begin
      state <= ST_IDLE;
      scnt <= '0;
      tcnt <= '0;
      nplc_q <= '0;
      raw_q <= '0;
      err_q <= ERR_NONE;
    end else begin
      state <= state_d;
      scnt <= state == ST_SETTLE ? scnt + SW'(tick_1ms) : '0;
      tcnt <= state == ST_WAIT ? tcnt + TW'(tick_1ms) : '0;
      if (state == ST_IDLE && enable) nplc_q <= nplc == '0 ? NPLC_W'(1) : nplc;
      if (state == ST_WAIT && conv_done) begin
        raw_q <= conv_result;
        err_q <= conv_err;
      end
    end
`ifdef ADC_AUTOZERO_EN
  logic [CNT_W-1:0] zero_ref;
  logic [CNT_W:0] diff;
  assign diff = {raw_q[CNT_W-1], raw_q} - {zero_ref[CNT_W-1], zero_ref};
  assign push_data = diff[CNT_W] != diff[CNT_W-1] ? {diff[CNT_W], {(CNT_W-1){~diff[CNT_W]}}} : diff[CNT_W-1:0];
  // Phase starts at zero on leaving IDLE and toggles each capture; a timeout leaves it untouched
  always_ff @(posedge clk)
    if (rst) begin
      ph <= 1'b1;
      zero_ref <= '0;
    end else begin
      if (state == ST_IDLE && enable) ph <= 1'b1;
      else if (state == ST_CAPTURE && enable) ph <= ~ph;
      if (state == ST_CAPTURE && err_q == ERR_NONE && ph) zero_ref <= raw_q;
    end
`else
  assign push_data = raw_q;
  // Every conversion measures the input once the scheduler has left IDLE
  always_ff @(posedge clk)
    ph <= rst ? 1'b1 : (state == ST_IDLE && enable) ? 1'b0 : ph;
`endif
  // Sticky status: a set event in the clear cycle still sets the bit
  always_ff @(posedge clk)
    if (rst) begin
      ovf <= 1'b0;
      tmo <= 1'b0;
      cerr <= 1'b0;
    end else begin
      ovf <= (push && full && !res_ready) || (ovf && !stat_clr);
      tmo <= (state == ST_WAIT && !conv_done && to_hit) || (tmo && !stat_clr);
      cerr <= (state == ST_CAPTURE && err_q != ERR_NONE) || (cerr && !stat_clr);
    end
  // Status word assembly
  always_comb begin
    stat = '0;
    stat[STAT_BUSY] = state != ST_IDLE;
    stat[STAT_CORE_ERR] = cerr;
    stat[STAT_TIMEOUT] = tmo;
    stat[STAT_OVERFLOW] = ovf;
  end
  adc_result_fifo #(.WIDTH(CNT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .din(push_data),
    .pop(res_ready),
    .dout(res_data),
    .full(full),
    .empty(empty)
  );
endmodule

// File: tb/tb_adc_conv_scheduler.sv
// tb_adc_conv_scheduler: directed scenario tasks against adc_conv_scheduler
module tb_adc_conv_scheduler;
`ifdef ADC_AUTOZERO_EN
  localparam bit AZ = 1'b1;
`else
  localparam bit AZ = 1'b0;
`endif
  logic clk = 0, rst = 1, tick_1ms = 0, enable = 0, conv_done = 0, res_ready = 0, stat_clr = 0;
  logic [9:0] nplc = 10'd20;
  logic [2:0] conv_err = 3'd0;
  logic [31:0] conv_result = 32'd0;
  logic conv_start, sel_zero, res_valid;
  logic [31:0] res_data;
  logic [3:0] stat;
  logic [31:0] vals [5] = '{32'd11, 32'hFFFF_FFEA, 32'd33, 32'd44, 32'd55};
  int total = 0, passed = 0;

  always #5 clk = ~clk;

  adc_conv_scheduler dut (
    .clk(clk), .rst(rst), .tick_1ms(tick_1ms), .enable(enable), .nplc(nplc),
    .conv_start(conv_start), .sel_zero(sel_zero), .conv_done(conv_done),
    .conv_err(conv_err), .conv_result(conv_result), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .stat_clr(stat_clr), .stat(stat)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic tick();
    tick_1ms = 1;
    step();
    tick_1ms = 0;
  endtask

  task automatic do_reset();
    rst = 1; enable = 0; res_ready = 0; stat_clr = 0; conv_done = 0; tick_1ms = 0;
    step(2);
    rst = 0;
  endtask

  // Ticks until conv_start is seen, then steps into WAIT
  task automatic go_start();
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) if (conv_start) seen = 1; else tick();
    if (!seen) begin
      $display("FAIL go_start: conv_start=0 want 1 within 20 ticks");
      $fatal(1);
    end
    step();
  endtask

  // One full conversion; returns at the negedge of the CAPTURE cycle
  task automatic conv(input logic [31:0] r, input logic [2:0] e, input int nt);
    go_start();
    repeat (nt) tick();
    conv_done = 1; conv_result = r; conv_err = e;
    step();
    conv_done = 0; conv_err = 3'd0; conv_result = 32'hDEAD_BEEF;
  endtask

  task automatic push_val(input logic [31:0] v);
    if (AZ) conv(32'd0, 3'd0, 2);
    conv(v, 3'd0, 2);
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (conv_start !== 1'b0) $display("FAIL reset_conv_start: got %b want 0", conv_start); else passed++;
    total++; if (sel_zero !== 1'b1) $display("FAIL reset_sel_zero: got %b want 1", sel_zero); else passed++;
    total++; if (res_valid !== 1'b0) $display("FAIL reset_res_valid: got %b want 0", res_valid); else passed++;
    total++; if (res_data !== 32'd0) $display("FAIL reset_res_data: got %h want 0", res_data); else passed++;
    total++; if (stat !== 4'b0000) $display("FAIL reset_stat: got %b want 0000", stat); else passed++;
  endtask

  task automatic test_start_latency();
    do_reset();
    nplc = 10'd20; enable = 1;
    step();
    total++; if (stat !== 4'b0001) $display("FAIL lat_busy: stat=%b want 0001", stat); else passed++;
    total++; if (sel_zero !== AZ) $display("FAIL lat_sel_zero: got %b want %b", sel_zero, AZ); else passed++;
    tick();
    total++; if (conv_start !== 1'b0) $display("FAIL lat_early_start: got %b want 0", conv_start); else passed++;
    tick();
    total++; if (conv_start !== 1'b1) $display("FAIL lat_start: got %b want 1", conv_start); else passed++;
    step();
    total++; if (conv_start !== 1'b0) $display("FAIL lat_pulse_width: got %b want 0", conv_start); else passed++;
  endtask

  task automatic test_main();
    do_reset();
    nplc = 10'd20; enable = 1;
    if (AZ) begin
      conv(32'd1000, 3'd0, 3);
      step();
    end
    total++; if (res_valid !== 1'b0) $display("FAIL main_zero_no_push: res_valid=%b want 0", res_valid); else passed++;
    conv(32'd5000, 3'd0, 3);
    total++; if (res_valid !== 1'b0) $display("FAIL main_capture_cycle: res_valid=%b want 0", res_valid); else passed++;
    step();
    total++; if (res_valid !== 1'b1) $display("FAIL main_valid: res_valid=%b want 1", res_valid); else passed++;
    total++; if (res_data !== (AZ ? 32'd4000 : 32'd5000)) $display("FAIL main_data: got %0d want %0d", res_data, AZ ? 4000 : 5000); else passed++;
    total++; if (sel_zero !== AZ) $display("FAIL main_next_phase: sel_zero=%b want %b", sel_zero, AZ); else passed++;
    res_ready = 1;
    step();
    res_ready = 0;
    total++; if (res_valid !== 1'b0) $display("FAIL main_once: res_valid=%b want 0", res_valid); else passed++;
  endtask

  task automatic test_saturation();
    do_reset();
    nplc = 10'd3; enable = 1;
    if (AZ) conv(32'h8000_0005, 3'd0, 2);
    conv(32'h7FFF_FFFF, 3'd0, 2);
    step();
    total++; if (res_data !== 32'h7FFF_FFFF) $display("FAIL sat_pos: got %h want 7fffffff", res_data); else passed++;
    res_ready = 1; step(); res_ready = 0;
    if (AZ) conv(32'h7FFF_FFFF, 3'd0, 2);
    conv(32'h8000_0000, 3'd0, 2);
    step();
    total++; if (res_data !== 32'h8000_0000) $display("FAIL sat_neg: got %h want 80000000", res_data); else passed++;
    res_ready = 1; step(); res_ready = 0;
  endtask

  task automatic test_timeout();
    do_reset();
    nplc = 10'd10; enable = 1;
    if (AZ) conv(32'd100, 3'd0, 2);
    go_start();
    total++; if (sel_zero !== 1'b0) $display("FAIL to_sel_input: got %b want 0", sel_zero); else passed++;
    repeat (13) tick();
    total++; if (stat !== 4'b0001) $display("FAIL to_before: stat=%b want 0001", stat); else passed++;
    stat_clr = 1; tick(); stat_clr = 0;
    total++; if (stat !== 4'b0100) $display("FAIL to_set_wins: stat=%b want 0100", stat); else passed++;
    step();
    total++; if (stat !== 4'b0101) $display("FAIL to_restart: stat=%b want 0101", stat); else passed++;
    total++; if (sel_zero !== AZ) $display("FAIL to_next_phase: sel_zero=%b want %b", sel_zero, AZ); else passed++;
    stat_clr = 1; step(); stat_clr = 0;
    total++; if (stat !== 4'b0001) $display("FAIL to_clear: stat=%b want 0001", stat); else passed++;
  endtask

  task automatic test_timeout_edges();
    do_reset();
    nplc = 10'd0; enable = 1;
    go_start();
    repeat (4) tick();
    total++; if (stat !== 4'b0001) $display("FAIL nplc0_before: stat=%b want 0001", stat); else passed++;
    tick();
    total++; if (stat !== 4'b0100) $display("FAIL nplc0_timeout: stat=%b want 0100", stat); else passed++;
    nplc = 10'd10; stat_clr = 1; step(); stat_clr = 0;
    go_start();
    repeat (13) tick();
    tick_1ms = 1; conv_done = 1; conv_result = 32'd9;
    step();
    tick_1ms = 0; conv_done = 0;
    total++; if (stat !== 4'b0001) $display("FAIL done_wins: stat=%b want 0001", stat); else passed++;
    step();
    total++; if (res_valid !== !AZ) $display("FAIL done_wins_push: res_valid=%b want %b", res_valid, !AZ); else passed++;
  endtask

  task automatic test_core_err();
    do_reset();
    nplc = 10'd5; enable = 1;
    conv(32'd777, 3'd3, 2);
    step();
    total++; if (res_valid !== 1'b0) $display("FAIL err_no_push: res_valid=%b want 0", res_valid); else passed++;
    total++; if (stat !== 4'b0011) $display("FAIL err_set: stat=%b want 0011", stat); else passed++;
    stat_clr = 1; step(); stat_clr = 0;
    total++; if (stat[3:1] !== 3'b000) $display("FAIL err_clear: stat[3:1]=%b want 000", stat[3:1]); else passed++;
  endtask

  task automatic test_overflow();
    do_reset();
    nplc = 10'd3; enable = 1;
    for (int i = 0; i < 4; i++) push_val(vals[i]);
    step();
    total++; if (stat[3] !== 1'b0) $display("FAIL ovf_not_yet: overflow=%b want 0", stat[3]); else passed++;
    push_val(vals[4]);
    step();
    total++; if (stat[3] !== 1'b1) $display("FAIL ovf_set: overflow=%b want 1", stat[3]); else passed++;
    enable = 0; res_ready = 1;
    for (int i = 0; i < 4; i++) begin
      total++; if (res_valid !== 1'b1 || res_data !== vals[i]) $display("FAIL ovf_pop%0d: valid=%b data=%h want 1 %h", i, res_valid, res_data, vals[i]); else passed++;
      step();
    end
    res_ready = 0;
    total++; if (res_valid !== 1'b0) $display("FAIL ovf_drained: res_valid=%b want 0", res_valid); else passed++;
  endtask

  task automatic test_full_pushpop();
    logic [31:0] exp [4];
    exp = '{vals[1], vals[2], vals[3], 32'd66};
    do_reset();
    nplc = 10'd3; enable = 1;
    for (int i = 0; i < 4; i++) push_val(vals[i]);
    push_val(32'd66);
    res_ready = 1; step(); res_ready = 0;
    total++; if (stat[3] !== 1'b0) $display("FAIL pp_no_ovf: overflow=%b want 0", stat[3]); else passed++;
    enable = 0; res_ready = 1;
    for (int i = 0; i < 4; i++) begin
      total++; if (res_valid !== 1'b1 || res_data !== exp[i]) $display("FAIL pp_pop%0d: valid=%b data=%h want 1 %h", i, res_valid, res_data, exp[i]); else passed++;
      step();
    end
    res_ready = 0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    nplc = 10'd8; enable = 1;
    push_val(32'd123);
    step();
    total++; if (res_valid !== 1'b1) $display("FAIL rm_pre_valid: res_valid=%b want 1", res_valid); else passed++;
    go_start();
    rst = 1; step(); rst = 0;
    total++; if (conv_start !== 1'b0 || sel_zero !== 1'b1) $display("FAIL rm_ctrl: start=%b sel_zero=%b want 0 1", conv_start, sel_zero); else passed++;
    total++; if (res_valid !== 1'b0 || res_data !== 32'd0) $display("FAIL rm_fifo: valid=%b data=%h want 0 0", res_valid, res_data); else passed++;
    total++; if (stat !== 4'b0000) $display("FAIL rm_stat: stat=%b want 0000", stat); else passed++;
  endtask

  initial begin
    test_reset();
    test_start_latency();
    test_main();
    test_saturation();
    test_timeout();
    test_timeout_edges();
    test_core_err();
    test_overflow();
    test_full_pushpop();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/adc_conv_scheduler.md
# adc_conv_scheduler

Sequences the multi-slope converter core through repeated conversions: it selects the input or zero reference, waits for mux settling, issues the start pulse, and supervises each conversion with a timeout. It then converts raw counts into auto-zero-corrected results and buffers them in a small FIFO. The SPI readout side drains that FIFO. The block sits between the 1 ms timebase and the converter core on one side and the SPI register block on the other.

## Interface
- `CNT_W`, 32: width of converter result and output data (signed).
- `NPLC_W`, 10: width of integration-time request.
- `SETTLE_MS`, 2: 1 ms ticks to wait after a mux change before start.
- `TIMEOUT_MS`, 4: extra ticks beyond `nplc` before a conversion is declared hung.
- `FIFO_DEPTH`, 4: result buffer entries (power of 2).

Ports:
- `clk` in 1: system clock. Single clock domain.
- `rst` in 1: synchronous, active-high reset.
- `tick_1ms` in 1: one-cycle strobe every 1 ms.
- `enable` in 1: run continuous conversions while high.
- `nplc` in `NPLC_W`: integration time in ms. A value of 0 is treated as 1.
- `conv_start` out 1: one-cycle start pulse to the converter core.
- `sel_zero` out 1: 1 routes the zero reference to the integrator, 0 routes the input.
- `conv_done` in 1: one-cycle pulse when the core finishes rundown.
- `conv_err` in 3: core error code, valid with `conv_done`. 0 means OK.
- `conv_result` in `CNT_W`: signed composite count, valid with `conv_done`.
- `res_valid` out 1, `res_ready` in 1, `res_data` out `CNT_W`: result stream (valid/ready).
- `stat_clr` in 1: clears the sticky status bits.
- `stat` out 4: {overflow, timeout, core_err, busy}.

## Operation
States: IDLE, SETTLE, START, WAIT, CAPTURE.
- **IDLE**
  - When `enable`=1, latch `nplc` (0 becomes 1) and set the phase.
  - Go to SETTLE with the settle counter cleared.
- **SETTLE**
  - Drive `sel_zero` per the current phase.
  - Count `tick_1ms` strobes. On the `SETTLE_MS`-th strobe, go to START.
- **START**
  - Assert `conv_start` for exactly one cycle.
  - Clear the timeout counter and go to WAIT.
- **WAIT**
  - Count `tick_1ms` strobes.
  - If `conv_done` arrives, go to CAPTURE.
  - If the count reaches latched `nplc`+`TIMEOUT_MS` first, set sticky `timeout` and go to IDLE. The phase is not advanced.
  - If `conv_done` and the final tick occur in the same cycle, `conv_done` wins.
- **CAPTURE** (one cycle)
  - If `conv_err`≠0: set sticky `core_err` and discard the result.
  - Else, zero phase: store `conv_result` into `zero_ref`.
  - Else, input phase: push `conv_result` − `zero_ref`, saturated to signed `CNT_W`.
  - Advance the phase, then go to SETTLE if `enable`=1, otherwise IDLE.

Other rules:
- Phase order alternates zero → input → zero … The first conversion after reset or after leaving IDLE is a zero phase.
- `enable` falling mid-conversion does not abort: the current conversion finishes and is captured.
- `busy` = (state ≠ IDLE).
- FIFO full on push: the new result is dropped and sticky `overflow` is set.
- Push and pop in the same cycle while full: the pop happens first and the push succeeds.
- `stat_clr` clears the sticky bits. If a set event occurs in the same cycle as `stat_clr`, set wins.

## Timing
Reset values:
- `conv_start`=0, `sel_zero`=1, `res_valid`=0, `res_data`=0, `stat`=0.
- `zero_ref`=0, FIFO empty, state IDLE.

Latencies and timing rules:
- `enable` rise to first `conv_start`: 1 cycle to SETTLE, then `SETTLE_MS` ticks, then 1 cycle.
- `conv_done` to `res_valid` (empty FIFO, input phase): 2 cycles, one for CAPTURE and one for FIFO write.
- `res_data` comes straight from the FIFO head register. It is stable while `res_valid`=1 and `res_ready`=0.
- `sel_zero` changes only on the CAPTURE→SETTLE transition. It never changes between `conv_start` and `conv_done`.
- `rst` mid-conversion: all state returns to reset values on the next edge, and FIFO contents are lost.

## Configuration
- `ADC_AUTOZERO_EN` defined: zero/input alternation and subtraction as described above.
- Not defined:
  - Every conversion is an input phase.
  - `sel_zero` is held at 0 after leaving IDLE.
  - `zero_ref` is constant 0, so `res_data` = `conv_result`.
  - The subtractor and saturation logic are not instantiated.

## Structure
- Shared package `adc_pkg`:
  - state enum `sched_state_t`;
  - error code constants (`ERR_NONE`=0 … `ERR_N1`=5) matching the core;
  - status bit index constants.
- Sub-module `adc_result_fifo`: synchronous FIFO with parameters `WIDTH`/`DEPTH` and ports push/pop/full/empty, head-registered output.

## Test plan
- `nplc`=20, core model returns 1000 (zero), then 5000 (input): `res_data`=4000 exactly once, 2 cycles after the input `conv_done`.
- `zero_ref`=−2^31+5, input result 2^31−1: `res_data` saturates to 2^31−1 (0x7FFFFFFF).
- Core never pulses `conv_done`, `nplc`=10: after 14 ticks `stat[timeout]`=1, state returns to IDLE, and the next conversion starts with `sel_zero`=1.
- `conv_err`=3 on done: no push, `stat[core_err]`=1. `stat_clr` then clears it to 0.
- `res_ready`=0 with 5 input results pushed: FIFO holds the first 4, the 5th is dropped, `overflow`=1. Popping yields the 4 results in order.
- `rst` pulsed during WAIT: the next cycle shows all outputs at reset values and `res_valid`=0. Without `ADC_AUTOZERO_EN`: `sel_zero` stays 0 and `res_data` = `conv_result`.
